// File: rtl/md_controller.sv
// Iterative multiply/divide unit with HI/LO registers for a 5-stage MIPS pipeline.
// One radix-2 step per cycle; 33 cycles from issue to the HI/LO update.
module md_controller #(
  parameter logic [31:0] DIV0_Q = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wr_data,
  input  logic        id_hilo_use,
  input  logic        id_md_op,
  output logic        busy,
  output logic        md_stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_next;
  logic [5:0]  cnt;
  logic        is_div;
  logic        sign_a;
  logic        neg_res;
  logic [31:0] mag_b;
  logic [63:0] acc;

  // op[0] set means unsigned; op[1] set means divide.
  logic        a_neg, b_neg;
  logic [31:0] mag_a_in, mag_b_in;
  assign a_neg    = ~op[0] & src_a[31];
  assign b_neg    = ~op[0] & src_b[31];
  assign mag_a_in = a_neg ? -src_a : src_a;
  assign mag_b_in = b_neg ? -src_b : src_b;

  // Multiply step: {HI, multiplier} register, add multiplicand on LSB, shift right.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mag_b : 32'h0)};
  assign mul_next = {mul_sum, acc[31:1]};

  // Restoring divide step: {remainder, dividend->quotient} register.
  logic [32:0] div_shift, div_trial;
  logic [63:0] div_next;
  assign div_shift = acc[63:31];
  assign div_trial = div_shift - {1'b0, mag_b};
  assign div_next  = div_trial[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                   : {div_trial[31:0], acc[30:0], 1'b1};

  // With a zero divisor every trial succeeds, so the remainder ends up equal to
  // |src_a|; re-applying sign_a then reproduces src_a exactly for HI.
  logic [63:0] prod;
  logic [31:0] quot, rem, res_hi, res_lo;
  assign prod   = neg_res ? -acc : acc;
  assign quot   = neg_res ? -acc[31:0] : acc[31:0];
  assign rem    = sign_a ? -acc[63:32] : acc[63:32];
  assign res_hi = is_div ? rem : prod[63:32];
  assign res_lo = is_div ? ((mag_b == 32'h0) ? DIV0_Q : quot) : prod[31:0];

  assign busy     = (state != IDLE);
  assign md_stall = (busy | start) & (id_hilo_use | id_md_op);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == 6'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 6'd0;
      is_div  <= 1'b0;
      sign_a  <= 1'b0;
      neg_res <= 1'b0;
      mag_b   <= 32'h0;
      acc     <= 64'h0;
      hi      <= 32'h0;
      lo      <= 32'h0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wr_data;
          if (lo_we) lo <= wr_data;
          if (start) begin
            is_div  <= op[1];
            sign_a  <= a_neg;
            neg_res <= a_neg ^ b_neg;
            mag_b   <= mag_b_in;
            acc     <= {32'h0, mag_a_in};
            cnt     <= 6'd0;
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          acc <= is_div ? div_next : mul_next;
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/md_controller.md
MD_CONTROLLER -- requirements
Module: md_controller

Interface
REQ-001 Parameter: DIV0_Q, 32'hFFFFFFFF, quotient written to LO on divide-by-zero.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  EX-stage mult/div issue, sampled only in IDLE.
REQ-005 op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
REQ-006 src_a  input  32  multiplicand / dividend; sampled with start.
REQ-007 src_b  input  32  multiplier / divisor; sampled with start.
REQ-008 hi_we  input  1  mthi write enable.
REQ-009 lo_we  input  1  mtlo write enable.
REQ-010 wr_data  input  32  mthi/mtlo data.
REQ-011 id_hilo_use  input  1  ID-stage instruction is mfhi/mflo/mthi/mtlo.
REQ-012 id_md_op  input  1  ID-stage instruction is mult/multu/div/divu.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 md_stall  output  1  stall request to hazard unit (freezes PC and IF/ID, bubbles ID/EX).
REQ-015 done  output  1  one-cycle pulse on completion.
REQ-016 hi  output  32  HI register.
REQ-017 lo  output  32  LO register.

Function
REQ-018 FSM states: IDLE, CALC, FIX; reset state IDLE.
REQ-019 IDLE: start=1 at edge k -> CALC; latch op, signs, |src_a| and |src_b| (unsigned ops: raw values); iteration counter = 0.
REQ-020 CALC: one radix-2 iteration per cycle; counter increments; after the 32nd iteration (edge k+32) -> FIX.
REQ-021 Multiply: shift-add on 64-bit accumulator of unsigned magnitudes.
REQ-022 Divide: restoring division, 32-bit quotient and 32-bit remainder of magnitudes.
REQ-023 FIX (edge k+33): sign correction, write hi/lo, -> IDLE; total latency start-edge to hi/lo update = 33 cycles.
REQ-024 mult: negate 64-bit product if sign(a) != sign(b); HI = [63:32], LO = [31:0].
REQ-025 div: LO = quotient, negated if sign(a) != sign(b); HI = remainder, negated if a negative.
REQ-026 -2^31 / -1 (div): LO = 32'h80000000, HI = 0; no trap.
REQ-027 src_b = 0 (div/divu): full 33-cycle sequence, then LO = DIV0_Q, HI = src_a as sampled.
REQ-028 done: registered, high exactly one cycle following the FIX edge; otherwise 0.
REQ-029 busy = (state != IDLE); combinational from state.
REQ-030 md_stall = (busy | start) & (id_hilo_use | id_md_op); combinational; start term covers the issue cycle.
REQ-031 start while busy: ignored, no operand resample (hazard stall prevents it; bench checks no corruption).
REQ-032 hi_we/lo_we in IDLE: write wr_data at that edge; while busy: ignored.
REQ-033 hi_we/lo_we and start at same IDLE edge: write applies; computed result overwrites at FIX.
REQ-034 hi/lo hold value in all states except the update edges above.

Reset
REQ-035 reset asserted: state IDLE, counter 0, hi = 0, lo = 0, done = 0, busy = 0, internal accumulators 0, immediately and regardless of clk.
REQ-036 reset mid-operation aborts; no hi/lo update and no done pulse for the aborted operation.
REQ-037 First start accepted at first rising edge after reset deasserts.

Verification
REQ-038 mult 7 x 32'hFFFFFFFD -> after 33 cycles HI=32'hFFFFFFFF, LO=32'hFFFFFFEB, done one cycle.
REQ-039 multu 32'hFFFFFFFF x 32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-040 div 32'hFFFFFFF9 / 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; divu 100 / 0 -> LO=32'hFFFFFFFF, HI=32'h00000064.
REQ-041 mult issued with mfhi in ID -> md_stall=1 from issue cycle through FIX cycle (34 cycles), 0 next cycle; mfhi then reads new HI.
REQ-042 reset pulse at cycle 10 of a div after mthi 5 -> hi=0, lo=0, busy=0, no done; next mult completes normally.
REQ-043 mtlo 32'hA5A5A5A5 while busy -> lo unchanged; same write in IDLE -> lo=32'hA5A5A5A5 next cycle.
